fifo_tree_arbiter: RTL and testbench
====================================

FIFO_TREE_ARBITER -- requirements
Module: fifo_tree_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CHILD, default 4, giving the number of child FIFO buffers merged into one parent (legal range 2..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 36, giving the word width.
REQ-003 The block SHALL have parameter GRANT_WIDTH, default $clog2(NUM_CHILD), giving the width of the grant index.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable_i  input  1  permits new grants.
REQ-007 child_nonempty_i  input  NUM_CHILD  bit k high = child k holds at least one word.
REQ-008 child_data_i  input  NUM_CHILD*DATA_WIDTH  registered read data of child k in slice [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 child_rden_o  output  NUM_CHILD  one-hot read strobe to the children.
REQ-010 parent_full_i  input  1  parent buffer full.
REQ-011 parent_wren_o  output  1  write strobe to the parent.
REQ-012 parent_data_o  output  DATA_WIDTH  word written to the parent.
REQ-013 grant_o  output  GRANT_WIDTH  index of the child served by the current or last transfer.
REQ-014 busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-015 xfer_count_o  output  32  number of completed parent writes; wraps modulo 2^32.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, CAPT and SEND; all outputs SHALL be registered.
REQ-017 In IDLE with enable_i=1, parent_full_i=0 and child_nonempty_i nonzero, the block SHALL grant the first nonempty child searching upward from (last_grant+1) mod NUM_CHILD, then update last_grant and grant_o and go to REQ.
REQ-018 In IDLE, if any grant condition of REQ-017 is false, the FSM SHALL remain in IDLE with all strobes low.
REQ-019 In REQ, child_rden_o SHALL be one-hot at the granted bit for exactly one cycle, and the FSM SHALL go to CAPT.
REQ-020 In CAPT, child_rden_o SHALL be zero and the FSM SHALL sample child_data_i of the granted child into parent_data_o at the closing edge, then go to SEND.
REQ-021 In SEND, parent_wren_o SHALL be high for exactly one cycle with parent_data_o stable; xfer_count_o SHALL increment at the closing edge; the next state SHALL be IDLE.
REQ-022 Latency SHALL be fixed: rden is asserted 1 cycle after the grant decision and wren 3 cycles after it; peak throughput SHALL be one word per 4 cycles.
REQ-023 The block SHALL be the parent's only writer, so parent_full_i=0 at grant guarantees the SEND write; parent_full_i SHALL be ignored outside IDLE.
REQ-024 Deasserting enable_i mid-transfer SHALL NOT abort the transfer; it only blocks the next grant.
REQ-025 Wrap-around: the round-robin search SHALL wrap from NUM_CHILD-1 to 0.
REQ-026 If the granted child's nonempty bit drops before REQ, the read SHALL still be issued; children SHALL never be read by any other agent, so this cannot occur in a legal tree.
REQ-027 parent_data_o SHALL hold its last value in all states except CAPT.

Reset
REQ-028 While reset is high, the block SHALL set state=IDLE, child_rden_o=0, parent_wren_o=0, parent_data_o=0, grant_o=0, busy_o=0 and xfer_count_o=0.
REQ-029 While reset is high, the block SHALL set last_grant=NUM_CHILD-1, so that child 0 has first priority.
REQ-030 Reset mid-transfer SHALL abort the transfer in the next cycle with no parent write; a word already read from a child is discarded, because the whole tree is reset together.

Structure
REQ-031 The FSM state enumeration and default DATA_WIDTH SHALL live in the shared package fifo_tree_pkg.
REQ-032 The round-robin search SHALL be a combinational sub-module rr_priority_picker (inputs: request vector, last grant; outputs: found, index) reusable by other tree nodes.

Verification
REQ-033 Scenario: reset, then child 2 only nonempty, enable=1 -> rden[2] pulses once; next cycle capture; wren with child 2's word; count=1; grant_o=2.
REQ-034 Scenario: all 4 children continuously nonempty -> grant order 0,1,2,3,0; wren every 4 cycles; count=5 after 20 cycles.
REQ-035 Scenario: parent_full_i=1 with children nonempty -> no rden, no wren; on release, a grant occurs on the next IDLE cycle.
REQ-036 Scenario: enable_i dropped in the REQ cycle -> the transfer completes with wren once, then the FSM stays in IDLE with busy_o=0.
REQ-037 Scenario: reset asserted in CAPT -> no wren ever for that word; all outputs are 0 the cycle after; the next grant goes to child 0.
REQ-038 Scenario: last_grant=3 and only child 1 nonempty -> the search wraps and grant_o=1.

Source files
------------

// File: rtl/fifo_tree_pkg.sv
// Shared definitions for FIFO-tree nodes: the arbiter FSM state encoding and the
// default word width.
package fifo_tree_pkg;

  localparam int DEFAULT_DATA_WIDTH = 36;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;
  localparam logic [1:0] ST_SEND = 2'd3;

endpackage

// File: rtl/fifo_tree_arbiter_picker.sv
// Combinational round-robin picker: finds the first set request bit searching
// upward from (last_i + 1) mod NUM_CHILD, wrapping to 0.
module rr_priority_picker #(
  parameter int NUM_CHILD   = 4,
  parameter int GRANT_WIDTH = $clog2(NUM_CHILD)
) (
  input  logic [NUM_CHILD-1:0]   req_i,
  input  logic [GRANT_WIDTH-1:0] last_i,
  output logic                   found_o,
  output logic [GRANT_WIDTH-1:0] idx_o
);

  logic [GRANT_WIDTH-1:0] cand;

  // Walk from the farthest offset down to the nearest so the nearest hit wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = NUM_CHILD; i >= 1; i--) begin
      cand = GRANT_WIDTH'((int'(last_i) + i) % NUM_CHILD);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_tree_arbiter.sv
// Merges NUM_CHILD child FIFOs into one parent FIFO with a fixed 4-cycle
// IDLE -> REQ -> CAPT -> SEND transfer and round-robin child selection.
module fifo_tree_arbiter
  import fifo_tree_pkg::*;
#(
  parameter int NUM_CHILD   = 4,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int GRANT_WIDTH = $clog2(NUM_CHILD)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable_i,
  input  logic [NUM_CHILD-1:0]            child_nonempty_i,
  input  logic [NUM_CHILD*DATA_WIDTH-1:0] child_data_i,
  output logic [NUM_CHILD-1:0]            child_rden_o,
  input  logic                            parent_full_i,
  output logic                            parent_wren_o,
  output logic [DATA_WIDTH-1:0]           parent_data_o,
  output logic [GRANT_WIDTH-1:0]          grant_o,
  output logic                            busy_o,
  output logic [31:0]                     xfer_count_o
);

  state_t                 state_q, state_d;
  logic [NUM_CHILD-1:0]   rden_q, rden_d;
  logic                   wren_q, wren_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [GRANT_WIDTH-1:0] grant_q, grant_d;
  logic [GRANT_WIDTH-1:0] last_q, last_d;
  logic                   busy_q, busy_d;
  logic [31:0]            count_q, count_d;

  logic                   pick_found;
  logic [GRANT_WIDTH-1:0] pick_idx;
  logic [DATA_WIDTH-1:0]  sel_data;

  rr_priority_picker #(
    .NUM_CHILD  (NUM_CHILD),
    .GRANT_WIDTH(GRANT_WIDTH)
  ) u_picker (
    .req_i  (child_nonempty_i),
    .last_i (last_q),
    .found_o(pick_found),
    .idx_o  (pick_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_CHILD; k++) begin
      if (grant_q == GRANT_WIDTH'(k)) sel_data = child_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    rden_d  = '0;
    wren_d  = 1'b0;
    data_d  = data_q;
    grant_d = grant_q;
    last_d  = last_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i && !parent_full_i && pick_found) begin
          state_d = ST_REQ;
          grant_d = pick_idx;
          last_d  = pick_idx;
          rden_d  = NUM_CHILD'(1) << pick_idx;
        end
      end
      ST_REQ: state_d = ST_CAPT;
      // Child read data is registered, so it is valid during CAPT.
      ST_CAPT: begin
        data_d  = sel_data;
        wren_d  = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        count_d = count_q + 32'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rden_q  <= '0;
      wren_q  <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
      last_q  <= GRANT_WIDTH'(NUM_CHILD - 1);
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rden_q  <= rden_d;
      wren_q  <= wren_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign child_rden_o  = rden_q;
  assign parent_wren_o = wren_q;
  assign parent_data_o = data_q;
  assign grant_o       = grant_q;
  assign busy_o        = busy_q;
  assign xfer_count_o  = count_q;

endmodule

// File: tb/tb_fifo_tree_arbiter.sv
// Bench for fifo_tree_arbiter: child FIFO models, a scoreboard of words read from
// children, a table of single-transfer vectors and hand-written corner sequences.
module tb_fifo_tree_arbiter;

  localparam int NC = 4;
  localparam int DW = 36;
  localparam int GW = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable_i = 1'b0;
  logic [NC-1:0]     child_nonempty_i = '0;
  logic [NC*DW-1:0]  child_data_i;
  logic [NC-1:0]     child_rden_o;
  logic              parent_full_i = 1'b0;
  logic              parent_wren_o;
  logic [DW-1:0]     parent_data_o;
  logic [GW-1:0]     grant_o;
  logic              busy_o;
  logic [31:0]       xfer_count_o;

  fifo_tree_arbiter #(.NUM_CHILD(NC), .DATA_WIDTH(DW), .GRANT_WIDTH(GW)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable_i        (enable_i),
    .child_nonempty_i(child_nonempty_i),
    .child_data_i    (child_data_i),
    .child_rden_o    (child_rden_o),
    .parent_full_i   (parent_full_i),
    .parent_wren_o   (parent_wren_o),
    .parent_data_o   (parent_data_o),
    .grant_o         (grant_o),
    .busy_o          (busy_o),
    .xfer_count_o    (xfer_count_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Child FIFO models: registered read data, each word tagged with child index and sequence.
  logic [31:0]   rdcnt [NC] = '{32'd0, 32'd100, 32'd200, 32'd300};
  logic [DW-1:0] cdata [NC] = '{36'h0, 36'h0, 36'h0, 36'h0};

  always @(posedge clk) begin
    for (int k = 0; k < NC; k++) begin
      if (child_rden_o[k]) begin
        cdata[k] <= {4'(k), rdcnt[k]};
        rdcnt[k] <= rdcnt[k] + 32'd1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NC; k++) child_data_i[k*DW +: DW] = cdata[k];
  end

  typedef struct { int grant; logic [DW-1:0] word; } sb_t;
  sb_t sb[$];

  // A reset discards any word read but not yet written.
  always @(posedge clk) if (reset) sb.delete();

  always @(negedge clk) begin
    if (child_rden_o != '0) begin
      check("rden_onehot", 64'($onehot(child_rden_o)), 64'd1);
      for (int k = 0; k < NC; k++)
        if (child_rden_o[k]) sb.push_back('{k, {4'(k), rdcnt[k]}});
    end
    if (parent_wren_o) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_wren", 64'd1, 64'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("wr_data", 64'(parent_data_o), 64'(e.word));
        check("wr_grant", 64'(grant_o), 64'(e.grant));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    child_nonempty_i = '0;
    enable_i = 1'b1;
    parent_full_i = 1'b0;
    tick();
    tick();
    check("rst_rden", 64'(child_rden_o), 64'd0);
    check("rst_wren", 64'(parent_wren_o), 64'd0);
    check("rst_data", 64'(parent_data_o), 64'd0);
    check("rst_grant", 64'(grant_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_count", 64'(xfer_count_o), 64'd0);
    reset = 1'b0;
  endtask

  typedef struct { logic [NC-1:0] mask; logic en; logic full; int exp_grant; } vec_t;
  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_count;
    int grants[$];
    int wren_bad;
    int wr_n;
    int rd_n;
    logic [DW-1:0] pd;

    tbl[0] = '{4'b0100, 1'b1, 1'b0, 2};
    tbl[1] = '{4'b0000, 1'b1, 1'b0, -1};
    tbl[2] = '{4'b1111, 1'b0, 1'b0, -1};
    tbl[3] = '{4'b1111, 1'b1, 1'b1, -1};
    tbl[4] = '{4'b0011, 1'b1, 1'b0, 0};
    tbl[5] = '{4'b0011, 1'b1, 1'b0, 1};
    tbl[6] = '{4'b1010, 1'b1, 1'b0, 3};
    tbl[7] = '{4'b0010, 1'b1, 1'b0, 1};
    tbl[8] = '{4'b1001, 1'b1, 1'b0, 3};
    tbl[9] = '{4'b1000, 1'b1, 1'b0, 3};

    do_reset();
    exp_count = 0;
    for (int i = 0; i < 10; i++) begin
      child_nonempty_i = tbl[i].mask;
      enable_i = tbl[i].en;
      parent_full_i = tbl[i].full;
      tick();
      if (tbl[i].exp_grant >= 0) begin
        check("tbl_rden", 64'(child_rden_o), 64'(1) << tbl[i].exp_grant);
        check("tbl_grant", 64'(grant_o), 64'(tbl[i].exp_grant));
        check("tbl_busy_req", 64'(busy_o), 64'd1);
        child_nonempty_i = '0;
        enable_i = 1'b1;
        parent_full_i = 1'b0;
        tick();
        check("tbl_rden_capt", 64'(child_rden_o), 64'd0);
        tick();
        check("tbl_wren_send", 64'(parent_wren_o), 64'd1);
        tick();
        exp_count++;
        check("tbl_wren_idle", 64'(parent_wren_o), 64'd0);
        check("tbl_busy_idle", 64'(busy_o), 64'd0);
        check("tbl_count", 64'(xfer_count_o), 64'(exp_count));
      end else begin
        check("tbl_nogrant_rden", 64'(child_rden_o), 64'd0);
        check("tbl_nogrant_busy", 64'(busy_o), 64'd0);
        check("tbl_nogrant_count", 64'(xfer_count_o), 64'(exp_count));
      end
      child_nonempty_i = '0;
      enable_i = 1'b1;
      parent_full_i = 1'b0;
    end

    // All children busy: strict rotation, one write every 4 cycles.
    do_reset();
    child_nonempty_i = 4'b1111;
    wren_bad = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      for (int k = 0; k < NC; k++) if (child_rden_o[k]) grants.push_back(k);
      if (parent_wren_o != ((i % 4) == 3)) wren_bad++;
    end
    child_nonempty_i = '0;
    check("rot_ngrants", 64'(grants.size()), 64'd5);
    for (int j = 0; j < 5 && j < grants.size(); j++) check("rot_order", 64'(grants[j]), 64'(j % NC));
    check("rot_wren_spacing", 64'(wren_bad), 64'd0);
    check("rot_count", 64'(xfer_count_o), 64'd5);

    // Parent full stalls the grant; release grants on the next IDLE edge.
    child_nonempty_i = 4'b1111;
    parent_full_i = 1'b1;
    pd = parent_data_o;
    rd_n = 0;
    wr_n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (child_rden_o != '0) rd_n++;
      if (parent_wren_o) wr_n++;
    end
    check("full_no_rden", 64'(rd_n), 64'd0);
    check("full_no_wren", 64'(wr_n), 64'd0);
    check("full_data_hold", 64'(parent_data_o), 64'(pd));
    parent_full_i = 1'b0;
    tick();
    check("full_release_rden", 64'(child_rden_o), 64'b0010);
    child_nonempty_i = '0;
    tick();
    tick();
    tick();
    check("full_release_count", 64'(xfer_count_o), 64'd6);

    // Enable dropped during REQ: transfer completes, no further grants.
    child_nonempty_i = 4'b0001;
    tick();
    check("en_drop_rden", 64'(child_rden_o), 64'b0001);
    enable_i = 1'b0;
    rd_n = 0;
    wr_n = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (child_rden_o != '0) rd_n++;
      if (parent_wren_o) wr_n++;
    end
    check("en_drop_wren_once", 64'(wr_n), 64'd1);
    check("en_drop_no_rden", 64'(rd_n), 64'd0);
    check("en_drop_busy", 64'(busy_o), 64'd0);
    check("en_drop_count", 64'(xfer_count_o), 64'd7);

    // Reset during CAPT aborts the transfer; child 0 regains first priority.
    enable_i = 1'b1;
    child_nonempty_i = 4'b0100;
    tick();
    check("abort_rden", 64'(child_rden_o), 64'b0100);
    child_nonempty_i = '0;
    tick();
    check("abort_capt_busy", 64'(busy_o), 64'd1);
    reset = 1'b1;
    tick();
    check("abort_wren", 64'(parent_wren_o), 64'd0);
    check("abort_rden0", 64'(child_rden_o), 64'd0);
    check("abort_data", 64'(parent_data_o), 64'd0);
    check("abort_grant", 64'(grant_o), 64'd0);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_count", 64'(xfer_count_o), 64'd0);
    reset = 1'b0;
    child_nonempty_i = 4'b1111;
    tick();
    check("abort_next_rden", 64'(child_rden_o), 64'b0001);
    check("abort_next_grant", 64'(grant_o), 64'd0);
    child_nonempty_i = '0;
    tick();
    tick();
    tick();
    check("abort_next_count", 64'(xfer_count_o), 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
